mem_responder: RTL and testbench

- Memory-side responder for the CPU's external bus: `addr`, `read`, `write`, write data and read data.
- Services CPU read and write requests against an on-chip synchronous RAM, with a programmable number of wait states and a one-cycle `ready` pulse.
- Provides a front-panel load port so a program can be written into memory while the CPU is not running.
- Sits beside `cpu` at the top level: the CPU's `data_out` feeds `din`; this block's `dout` feeds the CPU's `data_in`.

---
 rtl/mem_pkg.sv | 20 ++
 rtl/mem_array.sv | 29 ++
 rtl/mem_responder.sv | 147 ++++++++++++++
 tb/tb_mem_responder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the CPU-side memory responder.
package mem_pkg;

    // Transaction sequencing states.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    // CPU mode encodings; 2'b11 is reserved and behaves like stop.
    localparam logic [1:0] CS_STOP = 2'b00;
    localparam logic [1:0] CS_LOAD = 2'b01;
    localparam logic [1:0] CS_RUN  = 2'b10;

    localparam int unsigned MAX_WAIT = 7;
    localparam int unsigned WCNT_W   = $clog2(MAX_WAIT + 1);

endpackage

// File: rtl/mem_array.sv
// Single-write-port RAM with a registered read port; contents are never reset.
module mem_array
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Write port and registered read port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the CPU bus: wait states, one-cycle ready,
// out-of-range / conflict error reporting and a front-panel load port.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned WAIT   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               cpustate,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W-1:0]        din,
    input  logic                     read,
    input  logic                     write,
    input  logic                     ld_we,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [DATA_W-1:0]        ld_data,
    output logic [DATA_W-1:0]        dout,
    output logic                     ready,
    output logic                     busy,
    output logic                     err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [WCNT_W-1:0] WAIT_INIT = (WAIT > 0) ? WCNT_W'(WAIT - 1) : '0;

    state_e              state_q, state_d;
    logic [WCNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic [DATA_W-1:0]   dout_q, dout_d;

    logic                run;
    logic                oor;
    logic                conflict;
    logic                access_ok;
    logic                cpu_we;
    logic                ld_wr;
    logic                mem_we;
    logic [AW-1:0]       waddr;
    logic [DATA_W-1:0]   wdata;
    logic [AW-1:0]       raddr;
    logic [DATA_W-1:0]   rdata;

    assign run       = (cpustate == CS_RUN);
    assign oor       = ((addr_q >> AW) != '0);
    assign conflict  = rd_q & wr_q;
    // Reset or leaving run mode during ACCESS suppresses both ready and the write.
    assign access_ok = (state_q == S_ACCESS) && run && !rst;
    assign cpu_we    = access_ok && wr_q && !rd_q && !oor;
    assign ld_wr     = (cpustate == CS_LOAD) && ld_we && !rst;
    assign mem_we    = cpu_we | ld_wr;
    assign waddr     = cpu_we ? addr_q[AW-1:0] : ld_addr;
    assign wdata     = cpu_we ? din_q : ld_data;
    // Present the live address in IDLE so read data is ready even with zero wait states.
    assign raddr     = (state_q == S_IDLE) ? addr[AW-1:0] : addr_q[AW-1:0];

    mem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

    assign ready = access_ok;
    assign err   = access_ok && (oor || conflict);
    assign busy  = (state_q == S_WAIT) || (state_q == S_ACCESS);
    assign dout  = dout_d;

    // Next-state, request latching, wait counting and read-data capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        din_d   = din_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        dout_d  = dout_q;

        if (access_ok && rd_q && !wr_q) begin
            dout_d = oor ? '0 : rdata;
        end

        case (state_q)
            S_IDLE: begin
                if (run && (read || write)) begin
                    addr_d  = addr;
                    din_d   = din;
                    rd_d    = read;
                    wr_d    = write;
                    cnt_d   = WAIT_INIT;
                    state_d = (WAIT > 0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                if (!run) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_ACCESS: begin
                state_d = run ? S_DONE : S_IDLE;
            end
            S_DONE: begin
                if (!read && !write) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            dout_q  <= dout_d;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: three instances (WAIT = 0, 1, 3) each
// driven by directed and random traffic against a plain array/queue model.
module tb_mem_responder;

    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic [7:0] d;
        logic       e;
    } exp_t;

    task automatic chk(input string nm, input int w, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s (WAIT=%0d) cycle %0d: got %0h, expected %0h", nm, w, cyc, act, req);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : inst
        localparam int unsigned W = (g == 0) ? 0 : ((g == 1) ? 1 : 3);

        logic        rst = 1'b1;
        logic [1:0]  cs = 2'b00;
        logic [15:0] addr = '0;
        logic [7:0]  din = '0;
        logic        rd = 1'b0;
        logic        wr = 1'b0;
        logic        ld_we = 1'b0;
        logic [7:0]  ld_addr = '0;
        logic [7:0]  ld_data = '0;
        logic [7:0]  dout;
        logic        ready, busy, err;
        logic        fin = 1'b0;

        logic [7:0]  ref_mem [256];
        logic [7:0]  ref_dout = '0;
        exp_t        q[$];
        exp_t        mon_e;

        mem_responder #(
            .ADDR_W (16),
            .DATA_W (8),
            .DEPTH  (256),
            .WAIT   (W)
        ) dut (
            .clk      (clk),
            .rst      (rst),
            .cpustate (cs),
            .addr     (addr),
            .din      (din),
            .read     (rd),
            .write    (wr),
            .ld_we    (ld_we),
            .ld_addr  (ld_addr),
            .ld_data  (ld_data),
            .dout     (dout),
            .ready    (ready),
            .busy     (busy),
            .err      (err)
        );

        // Monitor: compare every ready pulse against the oldest expected response.
        always @(negedge clk) begin
            if (ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready (WAIT=%0d) cycle %0d: got ready=1, expected 0", W, cyc);
                end else begin
                    mon_e = q.pop_front();
                    chk("ready_cycle", W, cyc, mon_e.cyc);
                    chk("dout", W, {24'h0, dout}, {24'h0, mon_e.d});
                    chk("err", W, {31'h0, err}, {31'h0, mon_e.e});
                    chk("busy_at_ready", W, {31'h0, busy}, 32'h1);
                end
            end else if (q.size() != 0 && cyc > q[0].cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_ready (WAIT=%0d) cycle %0d: got no ready, expected one at cycle %0d", W, cyc, q[0].cyc);
                void'(q.pop_front());
            end else if (err) begin
                checks++;
                errors++;
                $display("FAIL err_without_ready (WAIT=%0d) cycle %0d: got err=1, expected 0", W, cyc);
            end
        end

        task automatic tick();
            @(posedge clk);
            #1;
        endtask

        task automatic xact(input logic r, input logic w_, input logic [15:0] a, input logic [7:0] d, input int hold);
            int   c;
            logic in_range;
            exp_t e;
            in_range = (a < 16'd256);
            tick();
            cs   = 2'b10;
            addr = a;
            din  = d;
            rd   = r;
            wr   = w_;
            c    = cyc;
            if (r && w_) begin
                e.e = 1'b1;
            end else if (r) begin
                ref_dout = in_range ? ref_mem[a[7:0]] : 8'h00;
                e.e = !in_range;
            end else begin
                if (in_range) ref_mem[a[7:0]] = d;
                e.e = !in_range;
            end
            e.cyc = c + int'(W) + 1;
            e.d   = ref_dout;
            q.push_back(e);
            repeat (hold) tick();
            rd = 1'b0;
            wr = 1'b0;
            repeat (W + 3) tick();
            chk("idle_busy", W, {31'h0, busy}, 32'h0);
            chk("dout_hold", W, {24'h0, dout}, {24'h0, ref_dout});
        endtask

        task automatic load(input logic [7:0] la, input logic [7:0] lv);
            tick();
            cs      = 2'b01;
            ld_we   = 1'b1;
            ld_addr = la;
            ld_data = lv;
            ref_mem[la] = lv;
            tick();
            ld_we = 1'b0;
            cs    = 2'b10;
        endtask

        task automatic ignored_ld(input logic [7:0] la, input logic [1:0] mode);
            tick();
            cs      = mode;
            ld_we   = 1'b1;
            ld_addr = la;
            ld_data = ~ref_mem[la];
            tick();
            ld_we = 1'b0;
            cs    = 2'b10;
        endtask

        task automatic ignored_read(input logic [15:0] a, input logic [1:0] mode);
            tick();
            cs   = mode;
            addr = a;
            rd   = 1'b1;
            repeat (W + 4) tick();
            chk("ignored_busy", W, {31'h0, busy}, 32'h0);
            rd = 1'b0;
            tick();
            cs = 2'b10;
        endtask

        task automatic abort(input logic use_rst);
            int c;
            int ab;
            tick();
            cs   = 2'b10;
            addr = 16'h0030;
            din  = 8'hFF;
            wr   = 1'b1;
            c    = cyc;
            ab   = c + ((W == 0) ? 1 : ((W < 2) ? int'(W) : 2));
            while (cyc < ab) tick();
            wr = 1'b0;
            if (use_rst) rst = 1'b1;
            else         cs  = 2'b00;
            tick();
            chk("abort_busy", W, {31'h0, busy}, 32'h0);
            chk("abort_ready", W, {31'h0, ready}, 32'h0);
            if (use_rst) begin
                ref_dout = 8'h00;
                chk("abort_rst_dout", W, {24'h0, dout}, 32'h0);
                chk("abort_rst_err", W, {31'h0, err}, 32'h0);
            end
            rst = 1'b0;
            cs  = 2'b10;
            repeat (2) tick();
        endtask

        // Per-instance stimulus: reset, preload, directed cases, then random traffic.
        initial begin
            logic [7:0]  rv;
            logic [15:0] ra;
            int          kind;
            rst = 1'b1;
            repeat (3) tick();
            chk("reset_dout", W, {24'h0, dout}, 32'h0);
            chk("reset_ready", W, {31'h0, ready}, 32'h0);
            chk("reset_busy", W, {31'h0, busy}, 32'h0);
            chk("reset_err", W, {31'h0, err}, 32'h0);
            rst = 1'b0;

            cs = 2'b01;
            for (int i = 0; i < 256; i++) begin
                rv      = 8'($urandom);
                ld_we   = 1'b1;
                ld_addr = 8'(i);
                ld_data = rv;
                ref_mem[i] = rv;
                tick();
            end
            ld_we = 1'b0;

            load(8'h10, 8'hA5);
            load(8'h30, 8'h11);
            load(8'h00, 8'h5A);

            xact(1'b1, 1'b0, 16'h0010, 8'h00, 1);
            xact(1'b0, 1'b1, 16'h0020, 8'h3C, 6);
            xact(1'b1, 1'b0, 16'h0020, 8'h00, 1);
            xact(1'b1, 1'b0, 16'h0100, 8'h00, 2);
            xact(1'b0, 1'b1, 16'h0100, 8'h77, 3);
            xact(1'b1, 1'b0, 16'h0000, 8'h00, 1);
            xact(1'b1, 1'b1, 16'h0010, 8'h55, 2);
            xact(1'b1, 1'b0, 16'h0010, 8'h00, 1);

            abort(1'b0);
            xact(1'b1, 1'b0, 16'h0030, 8'h00, 1);
            abort(1'b1);
            xact(1'b1, 1'b0, 16'h0030, 8'h00, 1);

            ignored_ld(8'h40, 2'b10);
            ignored_ld(8'h41, 2'b00);
            ignored_read(16'h0010, 2'b01);
            ignored_read(16'h0010, 2'b11);
            xact(1'b1, 1'b0, 16'h0040, 8'h00, 1);
            xact(1'b1, 1'b0, 16'h0041, 8'h00, 1);

            for (int n = 0; n < 40; n++) begin
                kind = int'($urandom_range(0, 9));
                ra   = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 31));
                rv   = 8'($urandom);
                if (kind <= 3)      xact(1'b1, 1'b0, ra, rv, int'($urandom_range(1, 8)));
                else if (kind <= 6) xact(1'b0, 1'b1, ra, rv, int'($urandom_range(1, 8)));
                else if (kind == 7) xact(1'b1, 1'b1, ra, rv, int'($urandom_range(1, 8)));
                else if (kind == 8) load(ra[7:0], rv);
                else                ignored_ld(ra[7:0], 2'b10);
            end

            repeat (4) tick();
            chk("queue_drained", W, q.size(), 0);
            fin = 1'b1;
        end
    end

    // Bounded wait for all instances, then the summary.
    initial begin
        int t;
        t = 0;
        while (t < 60000 && !(inst[0].fin && inst[1].fin && inst[2].fin)) begin
            @(posedge clk);
            t++;
        end
        if (!(inst[0].fin && inst[1].fin && inst[2].fin)) begin
            checks++;
            errors++;
            $display("FAIL timeout: got unfinished stimulus after %0d cycles, expected completion", t);
        end
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
